// File: rtl/cdc_fifo_write_arbiter_if.sv
// Write-side bundle between requesters, the round-robin arbiter and the CDC FIFO write port.
// master = producers/FIFO side, slave = arbiter.
interface cdc_fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          w_full;
    logic                          w_almost_full;
    logic                          w_inc;
    logic [DATA_WIDTH-1:0]         w_data;
    logic                          busy;

    modport master (
        output req_valid, req_data, w_full, w_almost_full,
        input  req_ready, grant, w_inc, w_data, busy
    );

    modport slave (
        input  req_valid, req_data, w_full, w_almost_full,
        output req_ready, grant, w_inc, w_data, busy
    );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing one CDC FIFO write port among NUM_REQ producers,
// granting bursts of up to BURST_LEN words and throttling on the FIFO full flags.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from rr_ptr, nothing written
// BURST | owner holds the FIFO write port until burst done, last slot used, or owner dry
module cdc_fifo_write_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    cdc_fifo_write_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state;
    logic [NUM_REQ-1:0]     grant_q;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       burst_cnt;

    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    int                     cand;
    logic [IDX_W-1:0]       next_ptr;
    logic                   in_burst;
    logic                   owner_valid;
    logic                   write_now;
    logic                   last_word;
    logic                   burst_exit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!pick_found && bus.req_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign next_ptr    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign in_burst    = (state == BURST);
    assign owner_valid = bus.req_valid[owner];
    assign write_now   = in_burst & owner_valid & ~bus.w_full;
    assign last_word   = (burst_cnt == CNT_W'(BURST_LEN - 1));
    // A full FIFO stalls the burst even if the owner has gone dry
    assign burst_exit  = (write_now & (last_word | bus.w_almost_full))
                       | (in_burst & ~owner_valid & ~bus.w_full);

    assign bus.grant     = grant_q;
    assign bus.busy      = in_burst;
    assign bus.w_inc     = write_now;
    assign bus.w_data    = data_arr[owner];
    assign bus.req_ready = (in_burst && !bus.w_full) ? grant_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= BURST;
                        owner     <= pick_idx;
                        grant_q   <= NUM_REQ'(1) << pick_idx;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    if (burst_exit) begin
                        state     <= IDLE;
                        grant_q   <= '0;
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                    end else if (write_now) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed, table-driven bench for the round-robin FIFO write arbiter
// (NUM_REQ=2, DATA_WIDTH=8, BURST_LEN=4).
module tb_cdc_fifo_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cdc_fifo_write_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(8)) bus ();

    cdc_fifo_write_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [1:0] vld;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       full;
        logic       af;
        logic [1:0] e_grant;
        logic       e_inc;
        logic [7:0] e_data;
        logic [1:0] e_ready;
        logic       e_busy;
        logic       chk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t m(logic rst, logic [1:0] vld, logic [7:0] d0, logic [7:0] d1,
                               logic full, logic af, logic [1:0] e_grant, logic e_inc,
                               logic [7:0] e_data, logic [1:0] e_ready, logic e_busy,
                               logic chk);
        vec_t v;
        v.rst = rst; v.vld = vld; v.d0 = d0; v.d1 = d1; v.full = full; v.af = af;
        v.e_grant = e_grant; v.e_inc = e_inc; v.e_data = e_data;
        v.e_ready = e_ready; v.e_busy = e_busy; v.chk = chk;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then sample outputs before the rising edge
    task automatic run_row(input vec_t v, input string tag);
        @(negedge clk);
        reset             = v.rst;
        bus.req_valid     = v.vld;
        bus.req_data      = {v.d1, v.d0};
        bus.w_full        = v.full;
        bus.w_almost_full = v.af;
        #1;
        if (v.chk) begin
            check({tag, "_grant"}, {6'd0, bus.grant},     {6'd0, v.e_grant});
            check({tag, "_winc"},  {7'd0, bus.w_inc},     {7'd0, v.e_inc});
            check({tag, "_ready"}, {6'd0, bus.req_ready}, {6'd0, v.e_ready});
            check({tag, "_busy"},  {7'd0, bus.busy},      {7'd0, v.e_busy});
            if (v.e_inc) check({tag, "_wdata"}, bus.w_data, v.e_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.w_full        = 1'b0;
        bus.w_almost_full = 1'b0;

        // Reset, single requester, then both requesters alternating
        tbl.push_back(m(1, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0));
        tbl.push_back(m(0, 2'b01, 8'h10, 8'hEE, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1));
        tbl.push_back(m(0, 2'b01, 8'h10, 8'hEE, 0, 0, 2'b01, 1, 8'h10, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b01, 8'h11, 8'hEE, 0, 0, 2'b01, 1, 8'h11, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b01, 8'h12, 8'hEE, 0, 0, 2'b01, 1, 8'h12, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b01, 8'h13, 8'hEE, 0, 0, 2'b01, 1, 8'h13, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b01, 8'h14, 8'hEE, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1));
        tbl.push_back(m(0, 2'b01, 8'h14, 8'hEE, 0, 0, 2'b01, 1, 8'h14, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b01, 8'h15, 8'hEE, 0, 0, 2'b01, 1, 8'h15, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b01, 8'h16, 8'hEE, 0, 0, 2'b01, 1, 8'h16, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b01, 8'h17, 8'hEE, 0, 0, 2'b01, 1, 8'h17, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h20, 8'hA0, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1));
        tbl.push_back(m(0, 2'b11, 8'h20, 8'hA0, 0, 0, 2'b10, 1, 8'hA0, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h20, 8'hA1, 0, 0, 2'b10, 1, 8'hA1, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h20, 8'hA2, 0, 0, 2'b10, 1, 8'hA2, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h20, 8'hA3, 0, 0, 2'b10, 1, 8'hA3, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h20, 8'hA4, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1));
        tbl.push_back(m(0, 2'b11, 8'h20, 8'hA4, 0, 0, 2'b01, 1, 8'h20, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h21, 8'hA4, 0, 0, 2'b01, 1, 8'h21, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h22, 8'hA4, 0, 0, 2'b01, 1, 8'h22, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h23, 8'hA4, 0, 0, 2'b01, 1, 8'h23, 2'b01, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h24, 8'hA4, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1));
        tbl.push_back(m(0, 2'b11, 8'h24, 8'hA4, 0, 0, 2'b10, 1, 8'hA4, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h24, 8'hA5, 0, 0, 2'b10, 1, 8'hA5, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h24, 8'hA6, 0, 0, 2'b10, 1, 8'hA6, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b11, 8'h24, 8'hA7, 0, 0, 2'b10, 1, 8'hA7, 2'b10, 1, 1));
        tbl.push_back(m(0, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1));

        foreach (tbl[i]) run_row(tbl[i], $sformatf("tbl%0d", i));

        // w_full stalls three cycles after the 2nd write; burst then finishes 2 more
        run_row(m(0, 2'b01, 8'h30, 8'hEE, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1), "full_idle");
        run_row(m(0, 2'b01, 8'h30, 8'hEE, 0, 0, 2'b01, 1, 8'h30, 2'b01, 1, 1), "full_w1");
        run_row(m(0, 2'b01, 8'h31, 8'hEE, 0, 0, 2'b01, 1, 8'h31, 2'b01, 1, 1), "full_w2");
        run_row(m(0, 2'b01, 8'h32, 8'hEE, 1, 0, 2'b01, 0, 8'h00, 2'b00, 1, 1), "full_s1");
        run_row(m(0, 2'b01, 8'h32, 8'hEE, 1, 0, 2'b01, 0, 8'h00, 2'b00, 1, 1), "full_s2");
        run_row(m(0, 2'b01, 8'h32, 8'hEE, 1, 0, 2'b01, 0, 8'h00, 2'b00, 1, 1), "full_s3");
        run_row(m(0, 2'b01, 8'h32, 8'hEE, 0, 0, 2'b01, 1, 8'h32, 2'b01, 1, 1), "full_w3");
        run_row(m(0, 2'b01, 8'h33, 8'hEE, 0, 0, 2'b01, 1, 8'h33, 2'b01, 1, 1), "full_w4");
        run_row(m(0, 2'b00, 8'h00, 8'hEE, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1), "full_end");

        // Almost-full on the 2nd write ends the burst early and rotates ownership
        run_row(m(0, 2'b11, 8'h50, 8'h40, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1), "af_idle");
        run_row(m(0, 2'b11, 8'h50, 8'h40, 0, 0, 2'b10, 1, 8'h40, 2'b10, 1, 1), "af_w1");
        run_row(m(0, 2'b11, 8'h50, 8'h41, 0, 1, 2'b10, 1, 8'h41, 2'b10, 1, 1), "af_w2");
        run_row(m(0, 2'b11, 8'h50, 8'h42, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1), "af_gap");
        run_row(m(0, 2'b11, 8'h50, 8'h42, 0, 0, 2'b01, 1, 8'h50, 2'b01, 1, 1), "af_rot");

        // Owner 0 runs dry after 2 writes; requester 1 takes over
        run_row(m(0, 2'b11, 8'h51, 8'h60, 0, 0, 2'b01, 1, 8'h51, 2'b01, 1, 1), "dry_w2");
        run_row(m(0, 2'b10, 8'h52, 8'h60, 0, 0, 2'b01, 0, 8'h00, 2'b01, 1, 1), "dry_drop");
        run_row(m(0, 2'b10, 8'h52, 8'h60, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1), "dry_idle");
        run_row(m(0, 2'b10, 8'h52, 8'h60, 0, 0, 2'b10, 1, 8'h60, 2'b10, 1, 1), "dry_new");

        // Reset during the 3rd word of requester 1's burst; requester 0 wins afterwards
        run_row(m(0, 2'b11, 8'h70, 8'h61, 0, 0, 2'b10, 1, 8'h61, 2'b10, 1, 1), "rst_w2");
        run_row(m(1, 2'b11, 8'h70, 8'h62, 0, 0, 2'b10, 1, 8'h62, 2'b10, 1, 1), "rst_w3");
        run_row(m(0, 2'b11, 8'h70, 8'h63, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 1), "rst_after");
        run_row(m(0, 2'b11, 8'h70, 8'h63, 0, 0, 2'b01, 1, 8'h70, 2'b01, 1, 1), "rst_grant0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
